// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM: idle (arbitrate), request (wait for m_gnt), response (wait for m_rvalid).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Owner of the transaction currently in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Access-type code used for instruction fetches (full word).
  localparam logic [2:0] DM_WORD = 3'b000;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data port with a starvation counter that
// forces one fetch grant after STARVE_LIMIT data grants taken while a fetch waited.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant,   // arbitration decision is taken this cycle
  output logic sel_i    // 1 = fetch wins, 0 = data wins
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt;

  // Data port wins ties unless the fetch port has been passed over LIMIT times.
  always_comb begin
    sel_i = i_req && (!d_req || (starve_cnt == LIMIT));
  end

  // Count data grants made over a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 3'd0;
    end else if (grant) begin
      if (sel_i) begin
        starve_cnt <= 3'd0;
      end else if (i_req && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single request/grant/response memory port.
// Handshake: the memory side sees m_req held with stable fields until m_gnt; the
// response arrives as a one-cycle m_rvalid, possibly in the same cycle as m_gnt.
// Each client holds its req until its one-cycle ready pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_type,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_type,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q;
  logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  logic        we_q;
  logic [2:0]  type_q;
  logic        grant, complete, sel_i;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk   (clk),
    .reset (reset),
    .i_req (i_req),
    .d_req (d_req),
    .grant (grant),
    .sel_i (sel_i)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, arbitration strobe, completion detect and memory-side outputs.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_gnt) begin
          if (m_rvalid) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (m_rvalid) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset forces the control outputs low even before the first clock edge.
    m_req   = !reset && (state_q == ST_REQ);
    m_we    = m_req && we_q;
    busy    = !reset && (state_q != ST_IDLE);
    i_ready = !reset && complete && (owner_q == OWN_I);
    d_ready = !reset && complete && (owner_q == OWN_D);
  end

  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign m_type    = type_q;
  assign dbg_state = state_q;

  // Latch the winner's fields at arbitration; untouched until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_D;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      type_q  <= 3'd0;
    end else if (grant) begin
      if (sel_i) begin
        owner_q <= OWN_I;
        addr_q  <= i_addr;
        wdata_q <= 32'd0;
        we_q    <= 1'b0;
        type_q  <= DM_WORD;
      end else begin
        owner_q <= OWN_D;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        we_q    <= d_we;
        type_q  <= d_type;
      end
    end
  end

  // Capture read data on completion so each port keeps its last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else if (complete) begin
      if (owner_q == OWN_I) i_rdata_q <= m_rdata;
      else                  d_rdata_q <= m_rdata;
    end
  end

  // Present m_rdata in the completion cycle itself, the held copy afterwards.
  assign i_rdata = i_ready ? m_rdata : i_rdata_q;
  assign d_rdata = d_ready ? m_rdata : d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive D grants allowed while i_req is pending; legal range 1..7.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  instruction-fetch request; held high until i_ready.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_ready  out  1  one-cycle pulse: i_rdata valid, fetch complete.
REQ-007 i_rdata  out  32  fetched instruction.
REQ-008 d_req  in  1  data request; held high until d_ready.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_type  in  3  DMType code, passed through unchanged.
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_ready  out  1  one-cycle pulse: load data valid or store acknowledged.
REQ-014 d_rdata  out  32  load data.
REQ-015 m_req  out  1  memory request, held until m_gnt.
REQ-016 m_we  out  1  memory write enable, qualified by m_req.
REQ-017 m_type  out  3  access type; 3'b000 (word) for fetches.
REQ-018 m_addr  out  32  memory address.
REQ-019 m_wdata  out  32  memory write data.
REQ-020 m_gnt  in  1  memory accepted the request this cycle.
REQ-021 m_rvalid  in  1  response (read data or write ack) this cycle.
REQ-022 m_rdata  in  32  memory read data.
REQ-023 busy  out  1  high in any state other than IDLE.

Function
REQ-024 FSM states: IDLE, REQ, RESP; owner register: I or D.
REQ-025 IDLE transitions:
  - any request pending -> pick owner, latch addr/we/type/wdata, go to REQ next cycle;
  - d_req alone -> D; i_req alone -> I.
REQ-026 Both requests pending in IDLE:
  - D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
REQ-027 Fetch latches m_we=0, m_type=3'b000, m_wdata=0.
REQ-028 REQ state:
  - m_req=1 with the latched fields stable until m_gnt;
  - m_gnt=1 -> RESP;
  - m_gnt=1 and m_rvalid=1 in the same cycle -> complete directly (REQ-030).
REQ-029 RESP state: m_req=0; waits indefinitely for m_rvalid.
REQ-030 On completion (m_rvalid in RESP, or per REQ-028), in the same cycle:
  - owner's ready pulses 1 for one cycle;
  - owner's rdata = m_rdata, and holds that value until the next completion for that owner;
  - FSM -> IDLE.
REQ-031 Minimum latency from request to ready is 2 cycles: IDLE decision, then REQ with m_gnt and m_rvalid both high.
REQ-032 A new arbitration occurs only in IDLE; no back-to-back issue in the cycle after a completion.
REQ-033 Requests changing while busy are ignored until IDLE; the latched fields are never modified mid-transaction.
REQ-034 starve_cnt (3 bits):
  - increments on each D grant made while i_req=1, saturating at STARVE_LIMIT;
  - clears on any I grant;
  - holds otherwise.
REQ-035 m_rvalid in IDLE or REQ (without m_gnt) is ignored; it produces no ready pulse.

Reset
REQ-036 While reset is high, on the next clk edge:
  - FSM = IDLE, owner = D, starve_cnt = 0;
  - all latched fields = 0, i_rdata = 0, d_rdata = 0.
REQ-037 Output values during reset and after it: m_req=0, m_we=0, i_ready=0, d_ready=0, busy=0.
REQ-038 Reset mid-transaction abandons it: no ready pulse is produced, and a late m_rvalid is ignored per REQ-035.

Structure
REQ-039 The FSM state encoding and owner encoding belong in shared package mem_arb_pkg; DMType codes come from the existing shared control-encoding definitions.
REQ-040 One sub-module is natural: mem_arb_prio, which holds starve_cnt and the combinational owner select.

Verification
REQ-041 i_req=1, i_addr=0x40; m_gnt one cycle after m_req; m_rvalid 2 cycles later with 0x00000013 -> i_ready single pulse, i_rdata=0x13, m_we=0, m_type=0, busy low next cycle.
REQ-042 d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_type=3'b010; m_gnt delayed 3 cycles -> m_req/m_addr/m_wdata stable all 3 cycles; d_ready pulses on the ack.
REQ-043 i_req and d_req held high continuously, STARVE_LIMIT=4, zero-wait memory -> grant order D,D,D,D,I repeating.
REQ-044 m_gnt and m_rvalid high in the same REQ cycle with m_rdata=0x1234 -> completion in that cycle, d_rdata=0x1234.
REQ-045 reset asserted in RESP, then m_rvalid arrives after reset deasserts -> no ready pulse, busy=0, m_req=0.
